// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one dual-byte synchronous memory between port A (fetch) and port B (load/store)
//   Ports: clk, rst_n (asynchronous, active-low)
//          A: a_req, a_addr in; a_ack, a_rdata_high/_low out (port A is read-only)
//          B: b_req, b_we, b_addr, b_wdata_high/_low in; b_ack, b_rdata_high/_low out
//          memory: mem_address, mem_data_write_high/_low, mem_we out; mem_data_read_high/_low in
//          busy out (access in ISSUE or RESP)
//   Macro MEM_ARB_FIXED_PRIO_EN: when defined, port A always wins ties; default is round-robin.
module mem_port_arbiter #(
    parameter int data_width = 8,
    parameter int addr_width = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic [addr_width-1:0] a_addr,
    output logic                  a_ack,
    output logic [data_width-1:0] a_rdata_high,
    output logic [data_width-1:0] a_rdata_low,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [addr_width-1:0] b_addr,
    input  logic [data_width-1:0] b_wdata_high,
    input  logic [data_width-1:0] b_wdata_low,
    output logic                  b_ack,
    output logic [data_width-1:0] b_rdata_high,
    output logic [data_width-1:0] b_rdata_low,
    output logic [addr_width-1:0] mem_address,
    output logic [data_width-1:0] mem_data_write_high,
    output logic [data_width-1:0] mem_data_write_low,
    output logic                  mem_we,
    input  logic [data_width-1:0] mem_data_read_high,
    input  logic [data_width-1:0] mem_data_read_low,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                state, state_nx;
    logic                  grant, grant_nx;
    logic                  take, take_b, tie_b;
    logic [addr_width-1:0] address_nx;
    logic [data_width-1:0] write_high_nx, write_low_nx;
    logic                  we_nx, a_ack_nx, b_ack_nx;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign tie_b = 1'b0;
`else
    logic last_grant;
    // a tie goes to whichever port was not served last; B at reset so A wins the first tie
    assign tie_b = ~last_grant;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last_grant <= 1'b1;
        else if (take) last_grant <= take_b;
`endif

    always_comb begin
        take     = 1'b0;
        take_b   = 1'b0;
        a_ack_nx = 1'b0;
        b_ack_nx = 1'b0;
        case (state)
            IDLE: begin
                take   = a_req | b_req;
                take_b = b_req & (~a_req | tie_b);
            end
            ISSUE: begin
                a_ack_nx = ~grant;
                b_ack_nx = grant;
            end
            // the acked port still shows req this cycle, so only the other one may be served
            RESP: begin
                take   = grant ? a_req : b_req;
                take_b = ~grant;
            end
            default: ;
        endcase
        state_nx      = take ? ISSUE : (state == ISSUE ? RESP : IDLE);
        grant_nx      = take ? take_b : grant;
        address_nx    = take ? (take_b ? b_addr : a_addr) : mem_address;
        we_nx         = take & take_b & b_we;
        write_high_nx = take & take_b ? b_wdata_high : mem_data_write_high;
        write_low_nx  = take & take_b ? b_wdata_low : mem_data_write_low;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state               <= IDLE;
            grant               <= 1'b0;
            mem_address         <= '0;
            mem_we              <= 1'b0;
            mem_data_write_high <= '0;
            mem_data_write_low  <= '0;
            a_ack               <= 1'b0;
            b_ack               <= 1'b0;
        end else begin
            state               <= state_nx;
            grant               <= grant_nx;
            mem_address         <= address_nx;
            mem_we              <= we_nx;
            mem_data_write_high <= write_high_nx;
            mem_data_write_low  <= write_low_nx;
            a_ack               <= a_ack_nx;
            b_ack               <= b_ack_nx;
        end

    assign busy         = state != IDLE;
    assign a_rdata_high = mem_data_read_high;
    assign a_rdata_low  = mem_data_read_low;
    assign b_rdata_high = mem_data_read_high;
    assign b_rdata_low  = mem_data_read_low;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
    localparam int DW = 8;
    localparam int AW = 16;
`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req, a_ack, b_req, b_we, b_ack, mem_we, busy;
    logic [AW-1:0] a_addr, b_addr, mem_address, mem_address_p1;
    logic [DW-1:0] a_rdata_high, a_rdata_low, b_rdata_high, b_rdata_low;
    logic [DW-1:0] b_wdata_high, b_wdata_low;
    logic [DW-1:0] mem_data_write_high, mem_data_write_low, mem_data_read_high, mem_data_read_low;
    int            n_tests = 0;
    int            n_fail = 0;

    mem_port_arbiter #(.data_width(DW), .addr_width(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack),
        .a_rdata_high(a_rdata_high), .a_rdata_low(a_rdata_low),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
        .b_wdata_high(b_wdata_high), .b_wdata_low(b_wdata_low), .b_ack(b_ack),
        .b_rdata_high(b_rdata_high), .b_rdata_low(b_rdata_low),
        .mem_address(mem_address), .mem_data_write_high(mem_data_write_high),
        .mem_data_write_low(mem_data_write_low), .mem_we(mem_we),
        .mem_data_read_high(mem_data_read_high), .mem_data_read_low(mem_data_read_low),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // dual-byte synchronous memory: registered read of mem[addr], mem[addr+1]; write when mem_we
    logic [7:0] mem [0:65535];
    logic [7:0] ref_mem [0:65535];
    assign mem_address_p1 = mem_address + 16'd1;
    always @(posedge clk) begin
        mem_data_read_high <= mem[mem_address];
        mem_data_read_low  <= mem[mem_address_p1];
        if (mem_we) begin
            mem[mem_address]    = mem_data_write_high;
            mem[mem_address_p1] = mem_data_write_low;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // transaction-level model: cur = port being served (-1 none), ph 1 = access pending, 2 = acked
    int            cur = -1;
    int            ph = 0;
    int            last = 1;
    int            nxt;
    logic [AW-1:0] m_addr, m_nx;
    logic          m_we;
    logic [15:0]   m_wd, m_rd;

    task automatic serve(input int p);
        cur    = p;
        ph     = 1;
        last   = p;
        m_addr = p == 1 ? b_addr : a_addr;
        m_we   = p == 1 ? b_we : 1'b0;
        m_wd   = {b_wdata_high, b_wdata_low};
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            cur  = -1;
            ph   = 0;
            last = 1;
        end else if (cur >= 0 && ph == 1) begin
            ph   = 2;
            m_nx = m_addr + 16'd1;
            m_rd = {ref_mem[m_addr], ref_mem[m_nx]};
            if (m_we) begin
                ref_mem[m_addr] = m_wd[15:8];
                ref_mem[m_nx]   = m_wd[7:0];
            end
        end else begin
            nxt = -1;
            if (cur >= 0) nxt = (cur == 0 ? b_req : a_req) ? 1 - cur : -1;
            else if (a_req && b_req) nxt = FIXED ? 0 : 1 - last;
            else if (a_req) nxt = 0;
            else if (b_req) nxt = 1;
            if (nxt >= 0) serve(nxt);
            else begin
                cur = -1;
                ph  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_a_ack", a_ack, 0);
            chk("rst_b_ack", b_ack, 0);
            chk("rst_busy", busy, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_address", mem_address, 0);
            chk("rst_wdata", {mem_data_write_high, mem_data_write_low}, 0);
        end else begin
            chk("a_ack", a_ack, cur == 0 && ph == 2);
            chk("b_ack", b_ack, cur == 1 && ph == 2);
            chk("busy", busy, cur >= 0);
            chk("mem_we", mem_we, cur >= 0 && ph == 1 && m_we);
            if (cur >= 0 && ph == 1) chk("mem_address", mem_address, m_addr);
            if (cur >= 0 && ph == 1 && m_we) chk("mem_wdata", {mem_data_write_high, mem_data_write_low}, m_wd);
            if (cur == 0 && ph == 2) chk("a_rdata", {a_rdata_high, a_rdata_low}, m_rd);
            if (cur == 1 && ph == 2 && !m_we) chk("b_rdata", {b_rdata_high, b_rdata_low}, m_rd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ack(input bit p, output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        do begin
            tick();
            lat++;
            if (busy) nbusy++;
        end while (!(p ? b_ack : a_ack) && lat < 20);
        if (!(p ? b_ack : a_ack)) chk("ack_timeout", 0, 1);
    endtask

    task automatic drop(input bit p);
        tick();
        if (p) b_req = 1'b0;
        else a_req = 1'b0;
    endtask

    task automatic do_reset();
        a_req = 1'b0;
        b_req = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nb, k, bt, acks;
        bit first, bdrop, ahold, bhold;
        logic [7:0] orig;
        int seq[$];
        rst_n = 1'b1;
        a_req = 1'b0; a_addr = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata_high = '0; b_wdata_low = '0;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[16'h0010] = 8'hAB; ref_mem[16'h0010] = 8'hAB;
        mem[16'h0011] = 8'hCD; ref_mem[16'h0011] = 8'hCD;
        #1 rst_n = 1'b0;
        tick(); tick(); tick();
        chk("reset_busy", busy, 0);
        chk("reset_mem_we", mem_we, 0);
        chk("reset_acks", {a_ack, b_ack}, 0);
        rst_n = 1'b1;
        tick();

        a_addr = 16'h0010; a_req = 1'b1;
        wait_ack(0, lat, nb);
        chk("t1_latency", lat, 2);
        chk("t1_rdata", {a_rdata_high, a_rdata_low}, 16'hABCD);
        chk("t1_busy_cycles", nb, 2);
        drop(0);
        chk("t1_idle", busy, 0);

        b_addr = 16'h0200; b_we = 1'b1; b_wdata_high = 8'h12; b_wdata_low = 8'h34; b_req = 1'b1;
        wait_ack(1, lat, nb);
        chk("t2_b_latency", lat, 2);
        drop(1);
        b_we = 1'b0;
        a_addr = 16'h0200; a_req = 1'b1;
        wait_ack(0, lat, nb);
        chk("t2_a_rdata", {a_rdata_high, a_rdata_low}, 16'h1234);
        drop(0);

        do_reset();
        a_addr = 16'h0010; b_addr = 16'h0200; b_we = 1'b0;
        a_req = 1'b1; b_req = 1'b1;
        wait_ack(0, lat, nb);
        chk("t3_a_first", lat, 2);
        chk("t3_b_waiting", b_ack, 0);
        drop(0);
        wait_ack(1, lat, nb);
        chk("t3_b_two_after_a", lat, 1);
        chk("t3_b_rdata", {b_rdata_high, b_rdata_low}, 16'h1234);
        drop(1);
        a_req = 1'b1;
        wait_ack(0, lat, nb);
        drop(0);
        a_req = 1'b1; b_req = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (!(a_ack | b_ack) && k < 20);
        chk("t3_tie_winner_b", b_ack, !FIXED);
        first = b_ack;
        drop(first);
        wait_ack(!first, lat, nb);
        drop(!first);

        a_addr = 16'h0010; a_req = 1'b1;
        tick();
        b_addr = 16'h0200; b_we = 1'b0; b_req = 1'b1;
        bdrop = 1'b0; bt = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bdrop) b_req = 1'b0;
            if (a_ack) seq.push_back(0);
            if (b_ack) begin
                seq.push_back(1);
                bdrop = 1'b1;
                bt = i;
            end
        end
        chk("t4_grant_count", seq.size() >= 3, 1);
        if (seq.size() >= 3) chk("t4_order", {seq[0][7:0], seq[1][7:0], seq[2][7:0]}, 24'h000100);
        chk("t4_b_served_time", bt, 2);
        wait_ack(0, lat, nb);
        drop(0);

        b_addr = 16'hFFFF; b_we = 1'b1; b_wdata_high = 8'h55; b_wdata_low = 8'h66; b_req = 1'b1;
        wait_ack(1, lat, nb);
        chk("t5_latency", lat, 2);
        drop(1);
        b_we = 1'b0;
        chk("t5_mem_ffff", mem[16'hFFFF], 8'h55);
        chk("t5_mem_0000", mem[16'h0000], 8'h66);

        orig = mem[16'h0040];
        b_addr = 16'h0040; b_we = 1'b1; b_wdata_high = ~orig; b_wdata_low = 8'hBB; b_req = 1'b1;
        tick();
        chk("t6_we_in_issue", mem_we, 1);
        rst_n = 1'b0;
        b_req = 1'b0; b_we = 1'b0;
        #1;
        chk("t6_rst_we", mem_we, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ack", b_ack, 0);
        tick(); tick();
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (b_ack) acks++;
        end
        chk("t6_no_ack", acks, 0);
        chk("t6_idle", busy, 0);
        chk("t6_mem_unchanged", mem[16'h0040], orig);

        ahold = 1'b0; bhold = 1'b0;
        repeat (3000) begin
            tick();
            if (ahold || (!a_req && $urandom_range(0, 2) == 0)) begin
                ahold  = 1'b0;
                a_req  = ahold ? 1'b0 : 1'($urandom_range(0, 1) | !a_req);
                a_addr = $urandom_range(0, 7) == 0 ? 16'hFFFF : 16'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 31));
            end
            if (a_ack) ahold = 1'b1;
            if (bhold || (!b_req && $urandom_range(0, 2) == 0)) begin
                bhold        = 1'b0;
                b_req        = 1'($urandom_range(0, 1) | !b_req);
                b_we         = 1'($urandom_range(0, 1));
                b_addr       = $urandom_range(0, 7) == 0 ? 16'hFFFF : 16'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 31));
                b_wdata_high = 8'($urandom);
                b_wdata_low  = 8'($urandom);
            end
            if (b_ack) bhold = 1'b1;
        end
        a_req = 1'b0; b_req = 1'b0;
        repeat (6) tick();
        chk("end_idle", busy, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
